// File: rtl/riscv_data_mem_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : riscv_data_mem_mc                                                 |
// | Multi-cycle RISC-V data memory: one load/store per valid/ready handshake,  |
// | a programmable number of wait states, and a one-cycle response pulse.      |
// | Supports byte/half/word(/double) accesses with sign/zero extension and     |
// | reports misaligned, illegal-funct3 and out-of-range accesses as rsp_err.   |
// |                                                                            |
// | Ports                                                                      |
// |   clk, rst          clock (rising edge), synchronous active-high reset     |
// |   req_valid/ready   request handshake; ready is high only while idle       |
// |   req_we            1 = store, 0 = load                                    |
// |   req_funct3        RISC-V load/store funct3                               |
// |   req_addr          byte address                                           |
// |   req_wdata         store data, low-order bytes used                       |
// |   rsp_valid         one-cycle response pulse                               |
// |   rsp_rdata         extended load data (0 for stores and errors)           |
// |   rsp_err           access fault, qualified by rsp_valid                   |
// |   mmio_out          MMIO register (only with RISCV_DMEM_MMIO_EN)           |
// |                                                                            |
// | Build option: define RISCV_DMEM_MMIO_EN to add the MMIO register at        |
// | MMIO_ADDR; otherwise MMIO_ADDR is an ordinary, range-checked address.      |
// |                                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module riscv_data_mem_mc #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 128,
  parameter int              LATENCY   = 1,
  parameter logic [XLEN-1:0] MMIO_ADDR = XLEN'(32'h0000_0FF0)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
`ifdef RISCV_DMEM_MMIO_EN
  ,
  output logic [XLEN-1:0] mmio_out
`endif
);

  localparam int         c_nbytes    = XLEN / 8;
  localparam int         c_offw      = $clog2(c_nbytes);
  localparam int         c_idxw      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         c_wordw     = XLEN - c_offw;
  localparam logic [1:0] c_full_size = (XLEN == 64) ? 2'd3 : 2'd2;
  localparam logic [3:0] c_cnt_last  = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Power-up contents: word i holds the value i. Reset never touches it.
  function automatic logic [DEPTH*XLEN-1:0] f_mem_init();
    logic [DEPTH*XLEN-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i*XLEN +: XLEN] = XLEN'(i);
    return v;
  endfunction

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [XLEN-1:0]       r_addr;
  logic [XLEN-1:0]       r_wdata;
  logic [DEPTH*XLEN-1:0] r_mem = f_mem_init();
  logic [XLEN-1:0]       r_mmio;

  logic [1:0]             w_size;
  logic [c_offw-1:0]      w_off;
  logic [c_idxw-1:0]      w_idx;
  logic                   w_misal;
  logic                   w_illegal;
  logic                   w_oor;
  logic                   w_mmio_hit;
  logic                   w_err;
  logic [XLEN-1:0]        w_rd_word;
  logic [XLEN-1:0]        w_aligned;
  logic [XLEN-1:0]        w_left;
  logic [XLEN-1:0]        w_zext;
  logic signed [XLEN-1:0] w_sext;
  logic [XLEN-1:0]        w_rdata;
  int                     w_shamt;
  logic [7:0]             w_mask8;
  logic [c_nbytes-1:0]    w_lane_en;
  logic [XLEN-1:0]        w_wdata_sh;

  // Decode of the captured request; everything here is evaluated in RESP.
  always_comb begin
    w_size     = r_funct3[1:0];
    w_off      = r_addr[c_offw-1:0];
    w_idx      = r_addr[c_offw +: c_idxw];

    w_misal = 1'b0;
    case (w_size)
      2'd1:    w_misal = w_off[0];
      2'd2:    w_misal = |w_off[1:0];
      2'd3:    w_misal = |w_off;
      default: w_misal = 1'b0;
    endcase

    w_illegal = r_we ? r_funct3[2] : (r_funct3 == 3'b111);
    if (XLEN == 32)
      w_illegal = w_illegal || (w_size == 2'd3) || (!r_we && r_funct3 == 3'b110);

    // Full upper address compared, so high bits never alias into the array.
    w_oor = (r_addr[XLEN-1:c_offw] >= c_wordw'(DEPTH));

`ifdef RISCV_DMEM_MMIO_EN
    w_mmio_hit = (r_addr == MMIO_ADDR);
    w_err      = w_illegal || w_misal || (w_mmio_hit ? (w_size != c_full_size) : w_oor);
`else
    w_mmio_hit = 1'b0;
    w_err      = w_illegal || w_misal || w_oor;
`endif

    // Load path: shift the addressed lane to bit 0, then sign/zero extend by
    // pushing the field to the top and shifting it back down.
    w_rd_word = w_oor ? '0 : r_mem[int'(w_idx)*XLEN +: XLEN];
    w_aligned = w_rd_word >> {w_off, 3'b000};
    w_shamt   = 0;
    case (w_size)
      2'd0:    w_shamt = XLEN - 8;
      2'd1:    w_shamt = XLEN - 16;
      2'd2:    w_shamt = XLEN - 32;
      default: w_shamt = 0;
    endcase
    w_left  = w_aligned << w_shamt;
    w_zext  = w_left >> w_shamt;
    w_sext  = $signed(w_left) >>> w_shamt;
    w_rdata = w_mmio_hit ? r_mmio : (r_funct3[2] ? w_zext : XLEN'(w_sext));

    // Store path: byte-enable mask and data moved onto the addressed lanes.
    w_mask8 = 8'h00;
    case (w_size)
      2'd0:    w_mask8 = 8'h01;
      2'd1:    w_mask8 = 8'h03;
      2'd2:    w_mask8 = 8'h0F;
      default: w_mask8 = 8'hFF;
    endcase
    w_lane_en  = c_nbytes'(w_mask8 << w_off);
    w_wdata_sh = r_wdata << {w_off, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      r_mmio    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_funct3  <= req_funct3;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_cnt     <= 4'd0;
            req_ready <= 1'b0;
            r_state   <= (LATENCY == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == c_cnt_last) r_state <= S_RESP;
          else                     r_cnt   <= r_cnt + 4'd1;
        end
        S_RESP: begin
          // Commit and load sample share this edge with the rising rsp_valid.
          rsp_valid <= 1'b1;
          rsp_err   <= w_err;
          rsp_rdata <= (w_err || r_we) ? '0 : w_rdata;
          if (!w_err && r_we) begin
            if (w_mmio_hit) begin
              r_mmio <= r_wdata;
            end else begin
              for (int b = 0; b < c_nbytes; b++)
                if (w_lane_en[b])
                  r_mem[int'(w_idx)*XLEN + b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
            end
          end
          req_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RISCV_DMEM_MMIO_EN
  assign mmio_out = r_mmio;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_data_mem_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_riscv_data_mem_mc                                              |
// | Directed bench for riscv_data_mem_mc: a LATENCY=1 instance carries the     |
// | load/store/error/reset sequence, a LATENCY=0 instance the back-to-back run.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_riscv_data_mem_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // LATENCY=1 instance
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b010;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  // LATENCY=0 instance
  logic        z_valid = 1'b0, z_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;
`ifdef RISCV_DMEM_MMIO_EN
  logic [31:0] mmio_out, z_mmio_out;
`endif

  riscv_data_mem_mc #(.XLEN(32), .DEPTH(128), .LATENCY(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
`ifdef RISCV_DMEM_MMIO_EN
    , .mmio_out(mmio_out)
`endif
  );

  riscv_data_mem_mc #(.XLEN(32), .DEPTH(128), .LATENCY(0)) dut_z (
    .clk(clk), .rst(rst), .req_valid(z_valid), .req_ready(z_ready),
    .req_we(1'b0), .req_funct3(3'b010), .req_addr(32'h10),
    .req_wdata(32'h0), .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err)
`ifdef RISCV_DMEM_MMIO_EN
    , .mmio_out(z_mmio_out)
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t  sb[$];
  string sb_tag[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every pulse pops one expected result.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        exp_t  e;
        string t;
        e = sb.pop_front();
        t = sb_tag.pop_front();
        check({t, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
        check({t, "_err"}, 64'(rsp_err), 64'(e.err));
      end
    end
  end

  // One transaction on the LATENCY=1 instance; response checked by the monitor.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd,
                     input logic exp_err, input string tag);
    int n;
    sb.push_back('{rdata: exp_rd, err: exp_err});
    sb_tag.push_back(tag);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check({tag, "_ready_timeout"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    // Inputs change right after the accept; the DUT must use its captured copy.
    req_valid = 1'b0; req_we = ~we; req_funct3 = ~f3; req_addr = ~addr; req_wdata = ~wdata;
    @(negedge clk); check({tag, "_v_n1"}, 64'(rsp_valid), 64'd0);
    @(negedge clk); check({tag, "_v_n2"}, 64'(rsp_valid), 64'd0);
    @(negedge clk); check({tag, "_v_n3"}, 64'(rsp_valid), 64'd1);
    @(negedge clk); check({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_err", 64'(rsp_err), 64'd0);
    check("rst_z_ready", 64'(z_ready), 64'd1);
`ifdef RISCV_DMEM_MMIO_EN
    check("rst_mmio", 64'(mmio_out), 64'd0);
`endif

    // LATENCY=0, req_valid held: accept every second edge.
    z_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_%0d", i), 64'(z_ready), 64'(i % 2));
      check($sformatf("b2b_valid_%0d", i), 64'(z_rsp_valid), 64'(i % 2));
      if (i % 2 == 1) check($sformatf("b2b_rdata_%0d", i), 64'(z_rsp_rdata), 64'd4);
    end
    z_valid = 1'b0;

    // Basic load and byte store / extension.
    txn(1'b0, 3'b010, 32'h10, 32'h0, 32'h0000_0004, 1'b0, "lw_10");
    txn(1'b1, 3'b000, 32'h11, 32'h0000_0080, 32'h0, 1'b0, "sb_11");
    txn(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFF_FF80, 1'b0, "lb_11");
    txn(1'b0, 3'b100, 32'h11, 32'h0, 32'h0000_0080, 1'b0, "lbu_11");
    txn(1'b0, 3'b010, 32'h10, 32'h0, 32'h0000_8004, 1'b0, "lw_10b");

    // Halfword and word stores with lane placement.
    txn(1'b1, 3'b001, 32'h16, 32'h1234_F00D, 32'h0, 1'b0, "sh_16");
    txn(1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF_F00D, 1'b0, "lh_16");
    txn(1'b0, 3'b101, 32'h16, 32'h0, 32'h0000_F00D, 1'b0, "lhu_16");
    txn(1'b0, 3'b010, 32'h14, 32'h0, 32'hF00D_0005, 1'b0, "lw_14");
    txn(1'b1, 3'b010, 32'h30, 32'h1234_ABCD, 32'h0, 1'b0, "sw_30");
    txn(1'b0, 3'b000, 32'h33, 32'h0, 32'h0000_0012, 1'b0, "lb_33");
    txn(1'b0, 3'b000, 32'h31, 32'h0, 32'hFFFF_FFAB, 1'b0, "lb_31");

    // Faults: misaligned, out of range, illegal funct3, and no write on error.
    txn(1'b0, 3'b001, 32'h03, 32'h0, 32'h0, 1'b1, "lh_mis");
    txn(1'b1, 3'b010, 32'h200, 32'hCAFE_F00D, 32'h0, 1'b1, "sw_oor");
    txn(1'b0, 3'b010, 32'h000, 32'h0, 32'h0, 1'b0, "lw_0_intact");
    txn(1'b0, 3'b010, 32'h1FC, 32'h0, 32'd127, 1'b0, "lw_last");
    txn(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h0, 1'b1, "lw_hi_alias");
    txn(1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, "ld_f3_111");
    txn(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, "ld_x32");
    txn(1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, "lwu_x32");
    txn(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, "st_f3_100");
    txn(1'b1, 3'b010, 32'h22, 32'hFFFF_FFFF, 32'h0, 1'b1, "sw_mis");
    txn(1'b0, 3'b010, 32'h10, 32'h0, 32'h0000_8004, 1'b0, "lw_10_intact");

    // Reset during WAIT of a store: no response, store dropped.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstmid_busy", 64'(req_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rstmid_novalid_%0d", i), 64'(rsp_valid), 64'd0);
    end
    txn(1'b0, 3'b010, 32'h20, 32'h0, 32'd8, 1'b0, "lw_20_after_rst");

`ifdef RISCV_DMEM_MMIO_EN
    txn(1'b1, 3'b010, 32'hFF0, 32'h0000_1234, 32'h0, 1'b0, "sw_mmio");
    check("mmio_out", 64'(mmio_out), 64'h1234);
    txn(1'b0, 3'b010, 32'hFF0, 32'h0, 32'h0000_1234, 1'b0, "lw_mmio");
    txn(1'b1, 3'b001, 32'hFF0, 32'h5555, 32'h0, 1'b1, "sh_mmio");
    check("mmio_hold", 64'(mmio_out), 64'h1234);
`else
    txn(1'b0, 3'b010, 32'hFF0, 32'h0, 32'h0, 1'b1, "lw_ff0_oor");
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
